// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   - state_e     : sequencer state encoding (RUN, MEM_WAIT, ERR)
//   - REG_AW_DEF  : default register-address width
//   - REG_ZERO    : index of the hard-wired zero register (never a hazard source)
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard comparator.
// Flags when the load in EX writes a non-zero register that the ID instruction reads.
// Ports:
//   ex_is_load_i, ex_rd_i           : load in EX and its destination register
//   id_rs1_i, id_rs2_i              : ID source registers
//   id_use_rs1_i, id_use_rs2_i      : ID actually reads that source
//   hazard_o                        : load-use hazard present this cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  output logic              hazard_o
);

  logic rd_nonzero_s;
  logic rs1_match_s;
  logic rs2_match_s;

  // Writes to the zero register are discarded, so they can never feed a consumer.
  assign rd_nonzero_s = (ex_rd_i != REG_AW'(REG_ZERO));
  assign rs1_match_s  = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_match_s  = id_use_rs2_i & (id_rs2_i == ex_rd_i);
  assign hazard_o     = ex_is_load_i & rd_nonzero_s & (rs1_match_s | rs2_match_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Drives the PC and pipeline-register write enables and NOP-load flush strobes,
// resolving data-memory waits, taken branches and load-use hazards
// (priority: memory stall > branch > load-use > normal).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   id_rs1/id_rs2/id_use_rs1/id_use_rs2 : ID-stage source operands
//   ex_is_load, ex_rd                : EX-stage load and destination
//   branch_taken                     : EX resolved a taken branch/jump
//   mem_req, mem_ready               : MEM-stage data-memory handshake
//   pc_we..memwb_we                  : register write enables (combinational)
//   ifid_flush/idex_flush/memwb_flush: load NOP into that register (combinational)
//   mem_err                          : sticky memory-wait timeout
//   stall_cnt, flush_cnt             : saturating performance counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              memwb_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_flush,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               hazard_s;
  logic               mstall_s;
  logic               br_flush_s;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_is_load_i (ex_is_load),
    .ex_rd_i      (ex_rd),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .hazard_o     (hazard_s)
  );

  // mem_ready without mem_req is a don't-care, so only a pending request can stall.
  assign mstall_s = mem_req & ~mem_ready;

  // Next-state logic and zero-latency enable/flush generation.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    br_flush_s  = 1'b0;

    if (rst) begin
      // Nothing loads while reset is held; the register block restarts the state.
      state_d = RUN;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (mstall_s) begin
            // Freeze PC..EX/MEM and push a bubble into WB while memory is busy.
            memwb_we    = 1'b1;
            memwb_flush = 1'b1;
            if (state_q == RUN) begin
              state_d    = MEM_WAIT;
              wait_cnt_d = WCNT_W'(1);
            end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
              state_d   = ERR;
              mem_err_d = 1'b1;
            end else begin
              wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
          end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
            pc_we      = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
            idex_we    = 1'b1;
            if (branch_taken) begin
              // Wrong-path IF/ID instructions are squashed; load-use is moot.
              ifid_we    = 1'b1;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              br_flush_s = 1'b1;
            end else if (hazard_s) begin
              // Hold PC and IF/ID one cycle, inserting a bubble behind the load.
              pc_we      = 1'b0;
              ifid_we    = 1'b0;
              idex_flush = 1'b1;
            end else begin
              ifid_we = 1'b1;
            end
          end
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          // Corrupted state encoding: lock down and report.
          state_d   = ERR;
          mem_err_d = 1'b1;
        end
      endcase
    end
  end

  // Saturating counter next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_we && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (br_flush_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State, wait counter, sticky error and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (TIMEOUT=4, CNT_W=3): a directed vector
// table followed by randomized traffic checked against a cycle reference model.
module tb_pipe_ctrl;

  localparam int TO   = 4;
  localparam int CMAX = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, branch_taken, mem_req, mem_ready;
  logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic       ifid_flush, idex_flush, memwb_flush, mem_err;
  logic [2:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(5), .TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2, ld;
    logic [4:0] rd;
    logic       br, req, rdy;
    logic [4:0] we;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0] fl;   // {ifid, idex, memwb}
    logic       chk;  // counters/mem_err are defined
    logic       err;
    logic [2:0] st, fc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic ld, input logic [4:0] rd,
                     input logic br, input logic req, input logic rdy,
                     input logic [4:0] we, input logic [2:0] fl, input logic chk,
                     input logic err, input int st, input int fc);
    vec_t v;
    v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ld = ld; v.rd = rd;
    v.br = br; v.req = req; v.rdy = rdy; v.we = we; v.fl = fl; v.chk = chk;
    v.err = err; v.st = 3'(st); v.fc = 3'(fc);
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_is_load = v.ld; ex_rd = v.rd; branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic check(input string tag, input vec_t v);
    logic [4:0] got_we;
    logic [2:0] got_fl;
    got_we = {pc_we, ifid_we, idex_we, exmem_we, memwb_we};
    got_fl = {ifid_flush, idex_flush, memwb_flush};
    n_cmp++;
    if (got_we !== v.we) begin
      n_bad++;
      $display("FAIL %s we: got %b expected %b @%0t", tag, got_we, v.we, $time);
    end
    n_cmp++;
    if (got_fl !== v.fl) begin
      n_bad++;
      $display("FAIL %s flush: got %b expected %b @%0t", tag, got_fl, v.fl, $time);
    end
    if (v.chk) begin
      n_cmp++;
      if (mem_err !== v.err) begin
        n_bad++;
        $display("FAIL %s mem_err: got %b expected %b @%0t", tag, mem_err, v.err, $time);
      end
      n_cmp++;
      if (stall_cnt !== v.st) begin
        n_bad++;
        $display("FAIL %s stall_cnt: got %0d expected %0d @%0t", tag, stall_cnt, v.st, $time);
      end
      n_cmp++;
      if (flush_cnt !== v.fc) begin
        n_bad++;
        $display("FAIL %s flush_cnt: got %0d expected %0d @%0t", tag, flush_cnt, v.fc, $time);
      end
    end
  endtask

  // Reference model: counts consecutive stalled cycles rather than tracking states.
  int m_consec, m_st, m_fc;
  bit m_err;

  task automatic model_expect(input vec_t v, output logic [4:0] we, output logic [2:0] fl);
    bit hz, ms;
    hz = v.ld && (v.rd != 5'd0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    ms = v.req && !v.rdy;
    if (v.rst || m_err) begin we = 5'b00000; fl = 3'b000; end
    else if (ms)        begin we = 5'b00001; fl = 3'b001; end
    else if (v.br)      begin we = 5'b11111; fl = 3'b110; end
    else if (hz)        begin we = 5'b00111; fl = 3'b010; end
    else                begin we = 5'b11111; fl = 3'b000; end
  endtask

  task automatic model_step(input vec_t v, input logic [4:0] we);
    bit ms;
    ms = v.req && !v.rdy;
    if (v.rst) begin
      m_consec = 0; m_err = 1'b0; m_st = 0; m_fc = 0;
    end else begin
      if (!we[4] && m_st < CMAX) m_st++;
      if (!m_err && !ms && v.br && m_fc < CMAX) m_fc++;
      if (!m_err) begin
        if (ms) begin
          m_consec++;
          if (m_consec == TO) m_err = 1'b1;
        end else begin
          m_consec = 0;
        end
      end
    end
  endtask

  initial begin
    // Reset held with a pending memory stall.
    add(1, 0,0,0,0,0,0, 0,1,0, 5'b00000, 3'b000, 0, 0,0,0);
    add(1, 0,0,0,0,0,0, 0,1,0, 5'b00000, 3'b000, 1, 0,0,0);
    add(0, 0,0,0,0,0,0, 0,0,0, 5'b11111, 3'b000, 1, 0,0,0);
    // Load-use on rs2, then same pattern targeting x0.
    add(0, 0,5,0,1,1,5, 0,0,0, 5'b00111, 3'b010, 1, 0,0,0);
    add(0, 0,0,0,1,1,0, 0,0,0, 5'b11111, 3'b000, 1, 0,1,0);
    // Branch wins over hazard.
    add(0, 0,5,0,1,1,5, 1,0,0, 5'b11111, 3'b110, 1, 0,1,0);
    add(0, 0,0,0,0,0,0, 0,0,0, 5'b11111, 3'b000, 1, 0,1,1);
    // Reset, then 3-cycle memory wait with branch held, then release.
    add(1, 0,0,0,0,0,0, 0,0,0, 5'b00000, 3'b000, 1, 0,1,1);
    for (int k = 0; k < 3; k++)
      add(0, 0,0,0,0,0,0, 1,1,0, 5'b00001, 3'b001, 1, 0,k,0);
    add(0, 0,0,0,0,0,0, 1,1,1, 5'b11111, 3'b110, 1, 0,3,0);
    add(0, 0,0,0,0,0,0, 0,0,0, 5'b11111, 3'b000, 1, 0,3,1);
    // Timeout after 4 stalled cycles; ERR ignores inputs; stall_cnt saturates.
    for (int k = 0; k < 4; k++)
      add(0, 0,0,0,0,0,0, 0,1,0, 5'b00001, 3'b001, 1, 0,3+k,1);
    add(0, 0,0,0,0,0,0, 1,1,1, 5'b00000, 3'b000, 1, 1,7,1);
    add(0, 0,0,0,0,0,0, 0,0,0, 5'b00000, 3'b000, 1, 1,7,1);
    add(1, 0,0,0,0,0,0, 0,0,0, 5'b00000, 3'b000, 1, 1,7,1);
    add(0, 0,0,0,0,0,0, 0,0,0, 5'b11111, 3'b000, 1, 0,0,0);
    // Hazard held 10 cycles (alternating rs1/rs2) -> stall_cnt sticks at 7.
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) add(0, 0,3,0,1,1,3, 0,0,0, 5'b00111, 3'b010, 1, 0,(k < 7) ? k : 7,0);
      else            add(0, 3,0,1,0,1,3, 0,0,0, 5'b00111, 3'b010, 1, 0,(k < 7) ? k : 7,0);
    end
    add(0, 0,0,0,0,0,0, 0,0,0, 5'b11111, 3'b000, 1, 0,7,0);
    // Matching registers but not used -> no hazard.
    add(0, 3,3,0,0,1,3, 0,0,0, 5'b11111, 3'b000, 1, 0,7,0);

    foreach (vq[i]) begin
      drive(vq[i]);
      #2;
      check($sformatf("vec%0d", i), vq[i]);
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the reference model.
    m_consec = 0; m_err = 1'b0; m_st = 0; m_fc = 0;
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      logic [4:0] ewe;
      logic [2:0] efl;
      v.rst = (i == 0) || ($urandom_range(0, 39) == 0);
      v.rs1 = 5'($urandom_range(0, 3));
      v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.u1  = 1'($urandom_range(0, 1));
      v.u2  = 1'($urandom_range(0, 1));
      v.ld  = 1'($urandom_range(0, 1));
      v.br  = ($urandom_range(0, 5) == 0);
      v.req = 1'($urandom_range(0, 1));
      v.rdy = ($urandom_range(0, 3) == 0);
      model_expect(v, ewe, efl);
      v.we  = ewe;
      v.fl  = efl;
      v.chk = (i != 0);
      v.err = m_err;
      v.st  = 3'(m_st);
      v.fc  = 3'(m_fc);
      drive(v);
      #2;
      check($sformatf("rnd%0d", i), v);
      @(posedge clk);
      #1;
      model_step(v, ewe);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
